// File: rtl/lsu_stage_pkg.sv
// Shared LSU definitions: datapath widths, access-size and FSM state encodings,
// and the size-alignment helper used by the optional misalignment trap.
package lsu_stage_pkg;

    localparam int XLEN = 64;
    localparam int RD_W = 5;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } lsu_state_e;

    // True when the low address bits are not a multiple of the access size.
    function automatic logic is_misaligned(input mem_size_e sz, input logic [2:0] lo);
        logic r;
        unique case (sz)
            SZ_H:    r = lo[0];
            SZ_W:    r = |lo[1:0];
            SZ_D:    r = |lo;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_stage_if.sv
// Handshake and bus bundle of the LSU stage: upstream op, memory bus, writeback.
// The slave modport is the stage itself; master is the surrounding pipeline/bus.
interface lsu_stage_if;
    import lsu_stage_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] ram_addr;
    logic [XLEN-1:0] st_data;
    logic            mem_rd;
    logic            mem_wr;
    logic [1:0]      mem_size;
    logic            mem_uns;
    logic [RD_W-1:0] rd;
    logic            rd_wen;

    logic            bus_req;
    logic            bus_we;
    logic [XLEN-1:0] bus_addr;
    logic [63:0]     bus_wdata;
    logic [7:0]      bus_wmask;
    logic            bus_gnt;
    logic            bus_rvalid;
    logic [63:0]     bus_rdata;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] wb_data;
    logic [RD_W-1:0] wb_rd;
    logic            wb_wen;
    logic            lsu_exc;

    modport slave (
        input  in_valid, alu_result, ram_addr, st_data, mem_rd, mem_wr,
               mem_size, mem_uns, rd, rd_wen,
        output in_ready,
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wmask,
        input  bus_gnt, bus_rvalid, bus_rdata,
        output out_valid, wb_data, wb_rd, wb_wen, lsu_exc,
        input  out_ready
    );

    modport master (
        output in_valid, alu_result, ram_addr, st_data, mem_rd, mem_wr,
               mem_size, mem_uns, rd, rd_wen,
        input  in_ready,
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wmask,
        output bus_gnt, bus_rvalid, bus_rdata,
        input  out_valid, wb_data, wb_rd, wb_wen, lsu_exc,
        output out_ready
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane alignment: store data/mask placement within a doubleword and
// load extraction with sign/zero extension. Purely combinational.
module lsu_align
    import lsu_stage_pkg::*;
(
    input  logic [2:0]  i_addr_lo,
    input  mem_size_e   i_size,
    input  logic        i_uns,
    input  logic [63:0] i_st_data,
    input  logic [63:0] i_rdata,
    output logic [63:0] o_wdata,
    output logic [7:0]  o_wmask,
    output logic [63:0] o_ld_data
);

    logic [5:0]  w_shamt;
    logic [63:0] w_rshift;
    logic [7:0]  w_base_mask;
    logic        w_sext;

    assign w_shamt  = {i_addr_lo, 3'b000};
    assign o_wdata  = i_st_data << w_shamt;
    assign w_rshift = i_rdata >> w_shamt;
    assign w_sext   = ~i_uns;
    assign o_wmask  = w_base_mask << i_addr_lo;

    always_comb begin
        w_base_mask = 8'h01;
        o_ld_data   = '0;
        unique case (i_size)
            SZ_B: begin
                w_base_mask = 8'h01;
                o_ld_data   = {{56{w_sext & w_rshift[7]}}, w_rshift[7:0]};
            end
            SZ_H: begin
                w_base_mask = 8'h03;
                o_ld_data   = {{48{w_sext & w_rshift[15]}}, w_rshift[15:0]};
            end
            SZ_W: begin
                w_base_mask = 8'h0F;
                o_ld_data   = {{32{w_sext & w_rshift[31]}}, w_rshift[31:0]};
            end
            SZ_D: begin
                w_base_mask = 8'hFF;
                o_ld_data   = w_rshift;
            end
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// LSU pipeline stage: one bus transaction per load/store, pass-through for other ops.
// Define LSU_MISALIGN_CHECK_EN to trap size-misaligned accesses instead of issuing them.
module lsu_stage
    import lsu_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    lsu_stage_if.slave lsu
);

    lsu_state_e      r_state;
    logic [XLEN-1:0] r_addr;
    logic [63:0]     r_st_data;
    mem_size_e       r_size;
    logic            r_uns;
    logic            r_is_st;
    logic            r_rd_wen;
    logic            r_bus_req;
    logic            r_out_valid;
    logic            r_wb_wen;
    logic            r_lsu_exc;
    logic [XLEN-1:0] r_wb_data;
    logic [RD_W-1:0] r_wb_rd;

    logic            w_is_mem;
    logic            w_resp;
    logic [63:0]     w_wdata;
    logic [7:0]      w_wmask;
    logic [63:0]     w_ld_data;

    assign w_is_mem = lsu.mem_rd || lsu.mem_wr;

    // A response completes the access either after the grant or together with it.
    assign w_resp = lsu.bus_rvalid &&
                    ((r_state == ST_WAIT) || (r_state == ST_REQ && lsu.bus_gnt));

    lsu_align u_align (
        .i_addr_lo (r_addr[2:0]),
        .i_size    (r_size),
        .i_uns     (r_uns),
        .i_st_data (r_st_data),
        .i_rdata   (lsu.bus_rdata),
        .o_wdata   (w_wdata),
        .o_wmask   (w_wmask),
        .o_ld_data (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_bus_req   <= 1'b0;
            r_out_valid <= 1'b0;
            r_wb_wen    <= 1'b0;
            r_lsu_exc   <= 1'b0;
            r_wb_data   <= '0;
            r_wb_rd     <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (lsu.in_valid) begin
                        r_addr    <= lsu.ram_addr;
                        r_st_data <= lsu.st_data;
                        r_size    <= mem_size_e'(lsu.mem_size);
                        r_uns     <= lsu.mem_uns;
                        r_is_st   <= lsu.mem_wr;
                        r_rd_wen  <= lsu.rd_wen;
                        r_wb_rd   <= lsu.rd;
                        r_lsu_exc <= 1'b0;
                        if (!w_is_mem) begin
                            r_wb_data   <= lsu.alu_result;
                            r_wb_wen    <= lsu.rd_wen;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end
`ifdef LSU_MISALIGN_CHECK_EN
                        else if (is_misaligned(mem_size_e'(lsu.mem_size), lsu.ram_addr[2:0])) begin
                            r_wb_data   <= lsu.ram_addr;
                            r_wb_wen    <= 1'b0;
                            r_lsu_exc   <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end
`endif
                        else begin
                            r_bus_req <= 1'b1;
                            r_state   <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (lsu.bus_gnt) begin
                        r_bus_req <= 1'b0;
                        r_state   <= lsu.bus_rvalid ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lsu.bus_rvalid) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (lsu.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
            endcase

            // Stores complete with an ack only; loads capture the aligned read data.
            if (w_resp) begin
                r_wb_data   <= r_is_st ? '0 : w_ld_data;
                r_wb_wen    <= r_is_st ? 1'b0 : r_rd_wen;
                r_out_valid <= 1'b1;
            end
        end
    end

    assign lsu.in_ready  = (r_state == ST_IDLE);
    assign lsu.bus_req   = r_bus_req;
    assign lsu.bus_we    = r_is_st;
    assign lsu.bus_addr  = {r_addr[XLEN-1:3], 3'b000};
    assign lsu.bus_wdata = w_wdata;
    assign lsu.bus_wmask = w_wmask;
    assign lsu.out_valid = r_out_valid;
    assign lsu.wb_data   = r_wb_data;
    assign lsu.wb_rd     = r_wb_rd;
    assign lsu.wb_wen    = r_wb_wen;
    assign lsu.lsu_exc   = r_lsu_exc;

endmodule
